// File: rtl/dir_pkg.sv
// Shared encodings for the directory request sequencer: request/queue opcodes,
// per-cache line-state bit positions and the sequencing FSM states.
package dir_pkg;

  localparam int OP_W     = 3;
  localparam int ST_W     = 2;
  localparam int ST_S_BIT = 0;
  localparam int ST_M_BIT = 1;

  localparam logic [OP_W-1:0] OP_NOOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_REPLY = 3'd2;
  localparam logic [OP_W-1:0] OP_RD    = 3'd3;
  localparam logic [OP_W-1:0] OP_WR    = 3'd4;
  localparam logic [OP_W-1:0] OP_INV   = 3'd5;
  localparam logic [OP_W-1:0] OP_UPD   = 3'd6;
  localparam logic [OP_W-1:0] OP_RWITM = 3'd7;
  // RWITM's code is reused on cache channels as read-and-invalidate
  localparam logic [OP_W-1:0] OP_RINV  = 3'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } dir_state_e;

endpackage

// File: rtl/dir_target_decode.sv
// Combinational decode of a latched directory request into the set of queue
// allocations (cache lanes + memory) and the mask of caches that must ack.
module dir_target_decode
  import dir_pkg::*;
#(
  parameter int NUM_CACHES = 2,
  parameter int ID_W       = $clog2(NUM_CACHES + 1)
) (
  input  logic [OP_W-1:0]                    op,
  input  logic [ID_W-1:0]                    src,
  input  logic [ID_W-1:0]                    dest,
  input  logic [ST_W*NUM_CACHES-1:0]         line_state,
  output logic [NUM_CACHES-1:0]              cache_alloc,
  output logic [NUM_CACHES-1:0][OP_W-1:0]    cache_op,
  output logic                               mem_alloc,
  output logic [OP_W-1:0]                    mem_op,
  output logic [NUM_CACHES-1:0]              ack_mask
);

  logic [NUM_CACHES-1:0] is_src, is_dest, other_valid, other_shared, src_m, src_s;
  logic                  src_mem;

  // Per-lane classification; the source cache is never an "other" cache.
  always_comb begin
    src_mem = (src == ID_W'(NUM_CACHES));
    for (int i = 0; i < NUM_CACHES; i++) begin
      is_src[i]       = (src == ID_W'(i));
      is_dest[i]      = (dest == ID_W'(i));
      other_valid[i]  = !is_src[i] && (line_state[ST_W*i+ST_M_BIT] || line_state[ST_W*i+ST_S_BIT]);
      other_shared[i] = !is_src[i] && line_state[ST_W*i+ST_S_BIT];
      src_m[i]        = is_src[i] && line_state[ST_W*i+ST_M_BIT];
      src_s[i]        = is_src[i] && line_state[ST_W*i+ST_S_BIT];
    end
  end

  // cache_op is per-lane intent; the top only forwards lanes that allocate.
  always_comb begin
    cache_alloc = '0;
    cache_op    = '0;
    mem_alloc   = 1'b0;
    mem_op      = OP_NOOP;
    ack_mask    = '0;
    case (op)
      OP_RD: begin
        cache_op = {NUM_CACHES{OP_RD}};
        if (|other_valid) cache_alloc = other_valid;
        else begin
          mem_alloc = 1'b1;
          mem_op    = OP_RD;
        end
      end
      OP_WR: begin
        cache_op = {NUM_CACHES{OP_WR}};
        if (!src_mem) begin
          mem_alloc = 1'b1;
          mem_op    = OP_WR;
        end else cache_alloc = is_dest;
      end
      OP_INV: begin
        if (|src_m) begin
          mem_alloc = 1'b1;
          mem_op    = OP_WR;
        end
      end
      OP_REPLY: begin
        cache_op    = {NUM_CACHES{OP_WR}};
        cache_alloc = is_dest;
      end
      OP_RWITM: begin
        for (int i = 0; i < NUM_CACHES; i++) cache_op[i] = is_src[i] ? OP_UPD : OP_RINV;
        if (|other_valid) begin
          cache_alloc = other_valid | is_src;
          ack_mask    = other_valid;
        end else begin
          mem_alloc = 1'b1;
          mem_op    = OP_RD;
        end
      end
      OP_UPD: begin
        for (int i = 0; i < NUM_CACHES; i++) cache_op[i] = is_src[i] ? OP_UPD : OP_INV;
        cache_alloc = other_shared | src_s;
        ack_mask    = other_shared;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/directory_req_sequencer.sv
// Accepts one directory request at a time, issues all its queue allocations
// atomically, waits for snoop acks (with timeout) and pulses completion.
module directory_req_sequencer
  import dir_pkg::*;
#(
  parameter int NUM_CACHES  = 2,
  parameter int ID_W        = $clog2(NUM_CACHES + 1),
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [OP_W-1:0]              req_op,
  input  logic [ID_W-1:0]              req_src,
  input  logic [ID_W-1:0]              req_dest,
  input  logic [ST_W*NUM_CACHES-1:0]   req_state,
  output logic [NUM_CACHES-1:0]        cache_q_alloc,
  output logic [OP_W*NUM_CACHES-1:0]   cache_q_op,
  input  logic [NUM_CACHES-1:0]        cache_q_full,
  output logic                         mem_q_alloc,
  output logic [OP_W-1:0]              mem_q_op,
  input  logic                         mem_q_full,
  input  logic [NUM_CACHES-1:0]        snoop_ack,
  output logic                         done_valid,
  output logic [OP_W-1:0]              done_op,
  output logic                         timeout_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  dir_state_e                      state, state_nxt;
  logic [OP_W-1:0]                 op_q;
  logic [ID_W-1:0]                 src_q, dest_q;
  logic [ST_W*NUM_CACHES-1:0]      st_q;
  logic [NUM_CACHES-1:0]           pend_q, pend_nxt;
  logic [CNT_W-1:0]                cnt_q;
  logic                            set_terr, fire;

  logic [NUM_CACHES-1:0]           dec_alloc, dec_mask;
  logic [NUM_CACHES-1:0][OP_W-1:0] dec_op, q_op;
  logic                            dec_mem_alloc;
  logic [OP_W-1:0]                 dec_mem_op;

  dir_target_decode #(.NUM_CACHES(NUM_CACHES), .ID_W(ID_W)) u_decode (
    .op          (op_q),
    .src         (src_q),
    .dest        (dest_q),
    .line_state  (st_q),
    .cache_alloc (dec_alloc),
    .cache_op    (dec_op),
    .mem_alloc   (dec_mem_alloc),
    .mem_op      (dec_mem_op),
    .ack_mask    (dec_mask)
  );

  assign cache_q_op = q_op;

  always_comb begin
    state_nxt     = state;
    pend_nxt      = pend_q;
    set_terr      = 1'b0;
    fire          = 1'b0;
    req_ready     = 1'b0;
    done_valid    = 1'b0;
    done_op       = OP_NOOP;
    cache_q_alloc = '0;
    q_op          = '0;
    mem_q_alloc   = 1'b0;
    mem_q_op      = OP_NOOP;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        // All-or-nothing: any targeted full queue holds back every alloc.
        fire = ((dec_alloc & cache_q_full) == '0) && !(dec_mem_alloc && mem_q_full);
        if (fire) begin
          cache_q_alloc = dec_alloc;
          mem_q_alloc   = dec_mem_alloc;
          mem_q_op      = dec_mem_op;
          for (int i = 0; i < NUM_CACHES; i++) q_op[i] = dec_alloc[i] ? dec_op[i] : OP_NOOP;
          pend_nxt  = dec_mask;
          state_nxt = (|dec_mask) ? WAIT_ACK : DONE;
        end
      end
      WAIT_ACK: begin
        pend_nxt = pend_q & ~snoop_ack;
        if (pend_nxt == '0) state_nxt = DONE;
        else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          set_terr  = 1'b1;
          pend_nxt  = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        done_op    = op_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_NOOP;
      src_q       <= '0;
      dest_q      <= '0;
      st_q        <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      if (state == IDLE && req_valid) begin
        op_q   <= req_op;
        src_q  <= req_src;
        dest_q <= req_dest;
        st_q   <= req_state;
      end
      if (state == WAIT_ACK) cnt_q <= (cnt_q == CNT_W'(ACK_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
      else cnt_q <= '0;
      if (set_terr) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_directory_req_sequencer.sv
// Bench for directory_req_sequencer: request-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_directory_req_sequencer;
  localparam int NC = 4;
  localparam int IW = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req_valid, req_ready, mem_q_alloc, mem_q_full, done_valid, timeout_err;
  logic [2:0]        req_op, mem_q_op, done_op;
  logic [IW-1:0]     req_src, req_dest;
  logic [2*NC-1:0]   req_state;
  logic [NC-1:0]     cache_q_alloc, cache_q_full, snoop_ack;
  logic [3*NC-1:0]   cache_q_op;

  directory_req_sequencer #(.NUM_CACHES(NC), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src(req_src), .req_dest(req_dest), .req_state(req_state),
    .cache_q_alloc(cache_q_alloc), .cache_q_op(cache_q_op), .cache_q_full(cache_q_full),
    .mem_q_alloc(mem_q_alloc), .mem_q_op(mem_q_op), .mem_q_full(mem_q_full),
    .snoop_ack(snoop_ack), .done_valid(done_valid), .done_op(done_op), .timeout_err(timeout_err));

  // Two-cache instance with default parameters
  logic       b_valid, b_ready, b_ma, b_mfull, b_done, b_terr;
  logic [2:0] b_op, b_mop, b_dop;
  logic [1:0] b_src, b_dest, b_ca, b_full, b_ack;
  logic [3:0] b_state;
  logic [5:0] b_co;

  directory_req_sequencer #(.NUM_CACHES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
    .req_src(b_src), .req_dest(b_dest), .req_state(b_state),
    .cache_q_alloc(b_ca), .cache_q_op(b_co), .cache_q_full(b_full),
    .mem_q_alloc(b_ma), .mem_q_op(b_mop), .mem_q_full(b_mfull),
    .snoop_ack(b_ack), .done_valid(b_done), .done_op(b_dop), .timeout_err(b_terr));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3*NC-1:0] opmask(input logic [NC-1:0] a);
    logic [3*NC-1:0] m;
    m = '0;
    for (int i = 0; i < NC; i++) if (a[i]) m[3*i+:3] = 3'b111;
    return m;
  endfunction

  // Targets straight from the request rules: who holds the line, who shares it.
  function automatic void model_targets(input logic [2:0] op, input int src, input int dest,
      input logic [2*NC-1:0] st, output logic [NC-1:0] ca, output logic [3*NC-1:0] co,
      output logic ma, output logic [2:0] mo, output logic [NC-1:0] msk);
    logic [NC-1:0] holders, sharers;
    holders = '0; sharers = '0; ca = '0; co = '0; ma = 1'b0; mo = 3'd0; msk = '0;
    for (int c = 0; c < NC; c++)
      if (c != src) begin
        holders[c] = (st[2*c+:2] != 2'b00);
        sharers[c] = st[2*c];
      end
    case (op)
      3'd3: if (holders != '0) begin
              ca = holders;
              for (int c = 0; c < NC; c++) if (holders[c]) co[3*c+:3] = 3'd3;
            end else begin ma = 1'b1; mo = 3'd3; end
      3'd4: if (src != NC) begin ma = 1'b1; mo = 3'd4; end
            else if (dest < NC) begin ca[dest] = 1'b1; co[3*dest+:3] = 3'd4; end
      3'd5: if (src < NC) begin if (st[2*src+1]) begin ma = 1'b1; mo = 3'd4; end end
      3'd2: if (dest < NC) begin ca[dest] = 1'b1; co[3*dest+:3] = 3'd4; end
      3'd7: if (holders != '0) begin
              ca = holders; msk = holders;
              for (int c = 0; c < NC; c++) if (holders[c]) co[3*c+:3] = 3'd7;
              if (src < NC) begin ca[src] = 1'b1; co[3*src+:3] = 3'd6; end
            end else begin ma = 1'b1; mo = 3'd3; end
      3'd6: begin
              ca = sharers; msk = sharers;
              for (int c = 0; c < NC; c++) if (sharers[c]) co[3*c+:3] = 3'd5;
              if (src < NC && st[2*src]) begin ca[src] = 1'b1; co[3*src+:3] = 3'd6; end
            end
      default: ;
    endcase
  endfunction

  // Model: 0=ready for request, 1=issuing, 2=awaiting acks, 3=completing
  int              ph = 0;
  int              wcnt = 0;
  logic [2:0]      l_op = 3'd0;
  logic [NC-1:0]   t_ca = '0, t_msk = '0, pend = '0;
  logic [3*NC-1:0] t_co = '0;
  logic            t_ma = 1'b0, m_terr = 1'b0;
  logic [2:0]      t_mo = 3'd0;

  always @(negedge clk) begin
    logic          can;
    logic [NC-1:0] e_ca;
    logic          e_ma;
    if (rst) begin ph = 0; m_terr = 1'b0; pend = '0; end
    can  = ((t_ca & cache_q_full) == '0) && !(t_ma && mem_q_full);
    e_ca = (ph == 1 && can) ? t_ca : '0;
    e_ma = (ph == 1 && can) && t_ma;
    chk("m_ready", 32'(req_ready), 32'(ph == 0));
    chk("m_c_alloc", 32'(cache_q_alloc), 32'(e_ca));
    chk("m_c_op", 32'(cache_q_op & opmask(e_ca)), 32'(t_co & opmask(e_ca)));
    chk("m_m_alloc", 32'(mem_q_alloc), 32'(e_ma));
    if (e_ma) chk("m_m_op", 32'(mem_q_op), 32'(t_mo));
    chk("m_done", 32'(done_valid), 32'(ph == 3));
    if (ph == 3) chk("m_done_op", 32'(done_op), 32'(l_op));
    chk("m_terr", 32'(timeout_err), 32'(m_terr));
    if (!rst) begin
      case (ph)
        0: if (req_valid) begin
             l_op = req_op;
             model_targets(req_op, int'(req_src), int'(req_dest), req_state, t_ca, t_co, t_ma, t_mo, t_msk);
             ph = 1;
           end
        1: if (can) begin
             if (t_msk != '0) begin pend = t_msk; wcnt = 0; ph = 2; end
             else ph = 3;
           end
        2: begin
             wcnt++;
             pend = pend & ~snoop_ack;
             if (pend == '0) ph = 3;
             else if (wcnt >= TO) begin m_terr = 1'b1; ph = 3; end
           end
        default: ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [IW-1:0] s, input logic [IW-1:0] d,
                      input logic [2*NC-1:0] st);
    int n = 0;
    while (!req_ready && n < 40) begin tick(); n++; end
    chk("send_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_src = s; req_dest = d; req_state = st;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic simple(input string nm, input logic [2:0] op, input logic [IW-1:0] s,
                        input logic [IW-1:0] d, input logic [2*NC-1:0] st, input logic [NC-1:0] eca,
                        input logic [3*NC-1:0] eco, input logic ema, input logic [2:0] emo);
    send(op, s, d, st);
    @(negedge clk);
    chk({nm, "_ca"}, 32'(cache_q_alloc), 32'(eca));
    chk({nm, "_co"}, 32'(cache_q_op & opmask(eca)), 32'(eco));
    chk({nm, "_ma"}, 32'(mem_q_alloc), 32'(ema));
    if (ema) chk({nm, "_mo"}, 32'(mem_q_op), 32'(emo));
    tick();
    @(negedge clk);
    chk({nm, "_done"}, 32'(done_valid), 32'd1);
    chk({nm, "_dop"}, 32'(done_op), 32'(op));
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_src = '0; req_dest = '0; req_state = '0;
    cache_q_full = '0; mem_q_full = 1'b0; snoop_ack = '0;
    b_valid = 1'b0; b_op = '0; b_src = '0; b_dest = '0; b_state = '0; b_full = '0; b_mfull = 1'b0; b_ack = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_alloc", 32'(cache_q_alloc), 'd0);
    chk("rst_done", 32'(done_valid), 'd0);
    chk("rst_terr", 32'(timeout_err), 'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 'd1);

    // Two caches: RD src0 with cache1 in M
    tick();
    chk("b_ready", 32'(b_ready), 'd1);
    b_valid = 1'b1; b_op = 3'd3; b_src = 2'd0; b_state = 4'b10_00;
    tick();
    b_valid = 1'b0;
    @(negedge clk);
    chk("b_ca", 32'(b_ca), 'b10);
    chk("b_co", 32'(b_co & 6'b111000), 'b011_000);
    chk("b_ma", 32'(b_ma), 'd0);
    chk("b_done_early", 32'(b_done), 'd0);
    tick();
    @(negedge clk);
    chk("b_done", 32'(b_done), 'd1);
    chk("b_dop", 32'(b_dop), 'd3);
    tick();
    @(negedge clk);
    chk("b_ready_again", 32'(b_ready), 'd1);

    //     name      op    src   dest  state {c3,c2,c1,c0} cache alloc  cache ops           mem   mop
    simple("rd_m",   3'd3, 3'd0, 3'd0, 8'b00_00_10_00, 4'b0010, 12'b000_000_011_000, 1'b0, 3'd0);
    simple("rd_mem", 3'd3, 3'd2, 3'd0, 8'b00_10_00_00, 4'b0000, 12'b000_000_000_000, 1'b1, 3'd3);
    simple("rd_two", 3'd3, 3'd1, 3'd0, 8'b10_00_10_01, 4'b1001, 12'b011_000_000_011, 1'b0, 3'd0);
    simple("wr_mc",  3'd4, 3'd4, 3'd1, 8'b00_00_00_00, 4'b0010, 12'b000_000_100_000, 1'b0, 3'd0);
    simple("wr_cm",  3'd4, 3'd0, 3'd2, 8'b00_00_00_00, 4'b0000, 12'b000_000_000_000, 1'b1, 3'd4);
    simple("wr_bad", 3'd4, 3'd4, 3'd5, 8'b00_00_00_00, 4'b0000, 12'b000_000_000_000, 1'b0, 3'd0);
    simple("inv_m",  3'd5, 3'd2, 3'd0, 8'b00_10_00_00, 4'b0000, 12'b000_000_000_000, 1'b1, 3'd4);
    simple("inv_s",  3'd5, 3'd2, 3'd0, 8'b00_01_00_00, 4'b0000, 12'b000_000_000_000, 1'b0, 3'd0);
    simple("reply",  3'd2, 3'd1, 3'd3, 8'b00_00_00_00, 4'b1000, 12'b100_000_000_000, 1'b0, 3'd0);
    simple("rwitm0", 3'd7, 3'd1, 3'd0, 8'b00_00_10_00, 4'b0000, 12'b000_000_000_000, 1'b1, 3'd3);
    simple("noop",   3'd0, 3'd0, 3'd0, 8'b11_11_11_11, 4'b0000, 12'b000_000_000_000, 1'b0, 3'd0);
    simple("undef",  3'd1, 3'd0, 3'd0, 8'b01_01_01_01, 4'b0000, 12'b000_000_000_000, 1'b0, 3'd0);

    // RWITM src0, caches 1,3 in S; acks in the alloc cycle are ignored
    send(3'd7, 3'd0, 3'd0, 8'b01_00_01_00);
    snoop_ack = 4'b1010;
    @(negedge clk);
    chk("rw_ca", 32'(cache_q_alloc), 'b1011);
    chk("rw_co", 32'(cache_q_op & opmask(4'b1011)), 'b111_000_111_110);
    chk("rw_ma", 32'(mem_q_alloc), 'd0);
    tick(); snoop_ack = 4'b1100;
    @(negedge clk); chk("rw_wait1", 32'(done_valid), 'd0);
    tick(); snoop_ack = 4'b0000;
    @(negedge clk); chk("rw_wait2", 32'(done_valid), 'd0);
    tick(); snoop_ack = 4'b0010;
    @(negedge clk); chk("rw_wait3", 32'(done_valid), 'd0);
    tick(); snoop_ack = 4'b0000;
    @(negedge clk);
    chk("rw_done", 32'(done_valid), 'd1);
    chk("rw_dop", 32'(done_op), 'd7);
    tick();

    // UPD stalled by a full cache2 queue for 5 cycles, then all allocs at once
    cache_q_full = 4'b0100;
    send(3'd6, 3'd0, 3'd0, 8'b10_01_01_01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("upd_stall_ca", 32'(cache_q_alloc), 'd0);
      chk("upd_stall_ma", 32'(mem_q_alloc), 'd0);
      tick();
    end
    cache_q_full = 4'b0000;
    @(negedge clk);
    chk("upd_ca", 32'(cache_q_alloc), 'b0111);
    chk("upd_co", 32'(cache_q_op & opmask(4'b0111)), 'b000_101_101_110);
    tick(); snoop_ack = 4'b0110;
    @(negedge clk); chk("upd_wait", 32'(done_valid), 'd0);
    tick(); snoop_ack = 4'b0000;
    @(negedge clk); chk("upd_done", 32'(done_valid), 'd1);
    tick();

    // Ack withheld: timeout after 8 WAIT_ACK cycles; stray ack to cache0 ignored
    send(3'd6, 3'd0, 3'd0, 8'b00_00_01_00);
    @(negedge clk);
    chk("to_ca", 32'(cache_q_alloc), 'b0010);
    chk("to_co", 32'(cache_q_op & opmask(4'b0010)), 'b000_000_101_000);
    for (int k = 0; k < 8; k++) begin
      tick();
      snoop_ack = (k == 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("to_wait_done", 32'(done_valid), 'd0);
      chk("to_wait_terr", 32'(timeout_err), 'd0);
    end
    tick(); snoop_ack = 4'b0000;
    @(negedge clk);
    chk("to_done", 32'(done_valid), 'd1);
    chk("to_terr", 32'(timeout_err), 'd1);
    tick();

    // Reset in WAIT_ACK abandons the transaction
    send(3'd6, 3'd0, 3'd0, 8'b00_00_01_00);
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_done", 32'(done_valid), 'd0);
    chk("rw_rst_terr", 32'(timeout_err), 'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done_valid), 'd0);
      chk("post_rst_ready", 32'(req_ready), 'd1);
      tick();
    end
    simple("rd_after", 3'd3, 3'd3, 3'd0, 8'b00_00_00_01, 4'b0001, 12'b000_000_000_011, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
